// File: rtl/text_buffer_writer.sv
// Write-port owner of the character RAM: accepts character/control codes, keeps a
// text cursor, and sweeps the screen to spaces after reset and on the clear command.
module text_buffer_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 4,
    parameter int unsigned AW   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [4:0]    in_code,
    output logic          in_ready,
    output logic [AW-1:0] address,
    output logic [4:0]    data,
    output logic          wren,
    output logic [6:0]    cur_col,
    output logic [1:0]    cur_row,
    output logic          busy
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam logic [4:0] CodeLastPrint = 5'd28;
    localparam logic [4:0] CodeBackspace = 5'd29;
    localparam logic [4:0] CodeClear     = 5'd30;

    typedef enum logic [1:0] {StIdle, StExec, StClear} state_e;

    state_e        state_q, state_d;
    logic [4:0]    code_q, code_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    data_q, data_d;
    logic          wren_q, wren_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [6:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [6:0]    bs_col;
    logic [1:0]    bs_row;

    function automatic logic [AW-1:0] lin(input logic [1:0] r, input logic [6:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    // Cell one step behind the cursor; only used when the cursor is not at (0,0).
    always_comb begin
        bs_col = col_q - 7'd1;
        bs_row = row_q;
        if (col_q == 7'd0) begin
            bs_col = 7'(COLS - 1);
            bs_row = row_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        ready_d = ready_q;
        busy_d  = busy_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (in_valid && ready_q) begin
                    code_d  = in_code;
                    ready_d = 1'b0;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StIdle;
                ready_d = 1'b1;
                if (code_q <= CodeLastPrint) begin
                    wren_d = 1'b1;
                    addr_d = lin(row_q, col_q);
                    data_d = code_q;
                    if (col_q == 7'(COLS - 1)) begin
                        col_d = 7'd0;
                        row_d = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end else if (code_q == CodeBackspace) begin
                    if (col_q != 7'd0 || row_q != 2'd0) begin
                        col_d  = bs_col;
                        row_d  = bs_row;
                        wren_d = 1'b1;
                        addr_d = lin(bs_row, bs_col);
                        data_d = 5'd0;
                    end
                end else if (code_q == CodeClear) begin
                    state_d = StClear;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    col_d = 7'd0;
                    row_d = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
                end
            end
            StClear: begin
                if (cnt_q == (AW + 1)'(CELLS)) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    col_d   = 7'd0;
                    row_d   = 2'd0;
                    state_d = StIdle;
                end else begin
                    wren_d = 1'b1;
                    addr_d = cnt_q[AW-1:0];
                    data_d = 5'd0;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            code_q  <= 5'd0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= 5'd0;
            wren_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            col_q   <= 7'd0;
            row_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign in_ready = ready_q;
    assign address  = addr_q;
    assign data     = data_q;
    assign wren     = wren_q;
    assign cur_col  = col_q;
    assign cur_row  = row_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer: reset sweep, printing, wrap, backspace,
// newline, clear command and reset during a sweep.
module tb_text_buffer_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_code = 5'd0;
    logic       in_ready;
    logic [9:0] address;
    logic [4:0] data;
    logic       wren;
    logic [6:0] cur_col;
    logic [1:0] cur_row;
    logic       busy;

    int checks = 0;
    int errors = 0;

    text_buffer_writer #(.COLS(80), .ROWS(4), .AW(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .address  (address),
        .data     (data),
        .wren     (wren),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input int a, input int d, input int c,
                             input int r);
        chk({tag, "_wren"}, 32'(wren), 1);
        chk({tag, "_addr"}, 32'(address), a);
        chk({tag, "_data"}, 32'(data), d);
        chk({tag, "_col"}, 32'(cur_col), c);
        chk({tag, "_row"}, 32'(cur_row), r);
    endtask

    // Presents a code and returns just after the accepting edge.
    task automatic send_code(input logic [4:0] c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_code  = c;
        while (in_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("handshake_timeout", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic step(input logic [4:0] c);
        send_code(c);
        tick();
    endtask

    // Entered with the FSM in the sweep state and no write shown yet.
    task automatic sweep(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (!(wren === 1'b1 && address === 10'(i) && data === 5'd0 && busy === 1'b1 &&
                  in_ready === 1'b0)) bad++;
        end
        chk({tag, "_bad_cycles"}, 32'(bad), 0);
        tick();
        chk({tag, "_end_wren"}, 32'(wren), 0);
        chk({tag, "_end_busy"}, 32'(busy), 0);
        chk({tag, "_end_ready"}, 32'(in_ready), 1);
        chk({tag, "_end_col"}, 32'(cur_col), 0);
        chk({tag, "_end_row"}, 32'(cur_row), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, 32'(address), 0);
        chk({tag, "_data"}, 32'(data), 0);
        chk({tag, "_wren"}, 32'(wren), 0);
        chk({tag, "_col"}, 32'(cur_col), 0);
        chk({tag, "_row"}, 32'(cur_row), 0);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
    endtask

    initial begin
        // Reset, then the power-on sweep
        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset("rst");
        rst_n = 1'b1;
        sweep("sweep0");

        // "AB" with in_valid held across both codes
        in_valid = 1'b1;
        in_code  = 5'd1;
        tick();
        chk("ab_gap_ready", 32'(in_ready), 0);
        chk("ab_gap_wren", 32'(wren), 0);
        in_code = 5'd2;
        tick();
        chk_write("a_write", 0, 1, 1, 0);
        chk("a_ready_back", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("b_gap_ready", 32'(in_ready), 0);
        tick();
        chk_write("b_write", 1, 2, 2, 0);

        // Wrap from end of row 0
        for (int i = 0; i < 77; i++) step(5'd0);
        chk("at_79_0_col", 32'(cur_col), 79);
        step(5'd27);
        chk_write("wrap_row", 79, 27, 0, 1);

        // Backspace across a row boundary
        step(5'd29);
        chk_write("bs_row", 79, 0, 79, 0);

        // Newlines back to (0,0), then backspace at origin
        step(5'd31);
        chk("nl_col", 32'(cur_col), 0);
        chk("nl_row", 32'(cur_row), 1);
        chk("nl_wren", 32'(wren), 0);
        step(5'd31);
        step(5'd31);
        step(5'd31);
        chk("nl_wrap_row", 32'(cur_row), 0);
        send_code(5'd29);
        chk("bs0_ready_low", 32'(in_ready), 0);
        chk("bs0_wren_exec", 32'(wren), 0);
        tick();
        chk("bs0_wren", 32'(wren), 0);
        chk("bs0_col", 32'(cur_col), 0);
        chk("bs0_row", 32'(cur_row), 0);
        chk("bs0_ready_back", 32'(in_ready), 1);

        // Wrap from the last cell
        for (int i = 0; i < 3; i++) step(5'd31);
        for (int i = 0; i < 79; i++) step(5'd0);
        chk("at_79_3_col", 32'(cur_col), 79);
        chk("at_79_3_row", 32'(cur_row), 3);
        step(5'd28);
        chk_write("wrap_last", 319, 28, 0, 0);

        // Newline from the last row; address/data hold the previous write
        for (int i = 0; i < 3; i++) step(5'd31);
        for (int i = 0; i < 5; i++) step(5'd3);
        send_code(5'd31);
        chk("nl3_wren_exec", 32'(wren), 0);
        tick();
        chk("nl3_wren", 32'(wren), 0);
        chk("nl3_col", 32'(cur_col), 0);
        chk("nl3_row", 32'(cur_row), 0);
        chk("nl3_addr_hold", 32'(address), 244);
        chk("nl3_data_hold", 32'(data), 3);

        // Clear command mid-screen with a code held pending throughout
        step(5'd1);
        step(5'd1);
        in_valid = 1'b1;
        in_code  = 5'd30;
        tick();
        in_code = 5'd5;
        tick();
        chk("clr_exec_wren", 32'(wren), 0);
        chk("clr_busy", 32'(busy), 1);
        chk("clr_ready", 32'(in_ready), 0);
        sweep("sweep_cmd");
        tick();
        in_valid = 1'b0;
        tick();
        chk_write("after_clr", 0, 5, 1, 0);

        // Reset at sweep count 100
        send_code(5'd30);
        tick();
        for (int i = 0; i < 101; i++) tick();
        chk("mid_addr", 32'(address), 100);
        chk("mid_wren", 32'(wren), 1);
        rst_n = 1'b0;
        tick();
        chk_reset("mid_rst");
        rst_n = 1'b1;
        sweep("sweep_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
